// File: rtl/legv8_pkg.sv
// LEGv8 multi-cycle control unit: shared encodings.
// States, opcodes, ALU function codes and ControlWord layout.
package legv8_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'b00,
    EXECUTE = 2'b01,
    HALT    = 2'b11
  } state_t;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_BC   = 8'b01010100;

  localparam logic [4:0] FS_AND   = 5'b00000;
  localparam logic [4:0] FS_ORR   = 5'b00100;
  localparam logic [4:0] FS_ADD   = 5'b01000;
  localparam logic [4:0] FS_SUB   = 5'b01001;
  localparam logic [4:0] FS_PASSA = 5'b01100;

  localparam logic [1:0] SZ_BYTE   = 2'b00;
  localparam logic [1:0] SZ_HALF   = 2'b01;
  localparam logic [1:0] SZ_WORD   = 2'b10;
  localparam logic [1:0] SZ_DOUBLE = 2'b11;

  localparam logic [1:0] DS_ALU = 2'b00;
  localparam logic [1:0] DS_REG = 2'b01;
  localparam logic [1:0] DS_MEM = 2'b11;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_BR   = 2'b10;

  // Bit offsets of each ControlWord field (LSB of the field).
  localparam int CW_AS    = 33;
  localparam int CW_DS    = 31;
  localparam int CW_PS    = 29;
  localparam int CW_PCSEL = 28;
  localparam int CW_BSEL  = 27;
  localparam int CW_IL    = 26;
  localparam int CW_SL    = 25;
  localparam int CW_FS    = 20;
  localparam int CW_C0    = 19;
  localparam int CW_SIZE  = 17;
  localparam int CW_MW    = 16;
  localparam int CW_RW    = 15;
  localparam int CW_DA    = 10;
  localparam int CW_SA    = 5;
  localparam int CW_SB    = 0;
  localparam int CW_W     = 34;

endpackage

// File: rtl/legv8_cond_eval.sv
// B.cond evaluator: maps cond[3:0] and {V,C,N,Z} to a taken bit.
// Odd codes invert the even base test, except 1111 which is always.
module legv8_cond_eval (
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_taken
);

  logic w_v, w_c, w_n, w_z;
  logic w_base;

  assign w_v = i_flags[3];
  assign w_c = i_flags[2];
  assign w_n = i_flags[1];
  assign w_z = i_flags[0];

  always_comb begin
    w_base = 1'b1;
    unique case (i_cond[3:1])
      3'b000: w_base = w_z;
      3'b001: w_base = w_c;
      3'b010: w_base = w_n;
      3'b011: w_base = w_v;
      3'b100: w_base = w_c & ~w_z;
      3'b101: w_base = (w_n == w_v);
      3'b110: w_base = ~w_z & (w_n == w_v);
      3'b111: w_base = 1'b1;
    endcase
  end

  assign o_taken = (i_cond[3:1] == 3'b111) ? 1'b1
                                           : (w_base ^ i_cond[0]);

endmodule

// File: rtl/legv8_control_unit.sv
// LEGv8 two-cycle control unit: FETCH loads IR, EXECUTE decodes it.
// Undefined opcodes park the FSM in HALT with an all-zero word.
module legv8_control_unit
  import legv8_pkg::*;
#(
  parameter state_t RESET_STATE = FETCH
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] IR_out,
  input  logic [4:0]  status,
  output logic [33:0] ControlWord,
  output logic [63:0] constant,
  output logic [1:0]  state,
  output logic [15:0] instr_count
);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_count;
  logic [33:0] w_cw;
  logic [63:0] w_const;
  logic        w_retire;

  logic [10:0] w_op11;
  logic [4:0]  w_rd, w_rn, w_rm;
  logic        w_rtype, w_itype, w_isub;
  logic        w_ldur, w_stur, w_b, w_cbz, w_bc;
  logic [4:0]  w_rfs;
  logic        w_rc0, w_rsl;
  logic        w_taken;

  assign w_op11 = IR_out[31:21];
  assign w_rd   = IR_out[4:0];
  assign w_rn   = IR_out[9:5];
  assign w_rm   = IR_out[20:16];

  assign w_itype = (IR_out[31:22] == OP_ADDI) |
                   (IR_out[31:22] == OP_SUBI);
  assign w_isub  = (IR_out[31:22] == OP_SUBI);
  assign w_ldur  = (w_op11 == OP_LDUR);
  assign w_stur  = (w_op11 == OP_STUR);
  assign w_b     = (IR_out[31:26] == OP_B);
  assign w_cbz   = (IR_out[31:24] == OP_CBZ);
  assign w_bc    = (IR_out[31:24] == OP_BC);

  always_comb begin
    w_rtype = 1'b1;
    w_rfs   = FS_ADD;
    w_rc0   = 1'b0;
    w_rsl   = 1'b0;
    unique case (w_op11)
      OP_ADD:  ;
      OP_SUB:  begin w_rfs = FS_SUB; w_rc0 = 1'b1; end
      OP_AND:  w_rfs = FS_AND;
      OP_ORR:  w_rfs = FS_ORR;
      OP_ADDS: w_rsl = 1'b1;
      OP_SUBS: begin
        w_rfs = FS_SUB;
        w_rc0 = 1'b1;
        w_rsl = 1'b1;
      end
      default: w_rtype = 1'b0;
    endcase
  end

  legv8_cond_eval u_cond (
    .i_cond  (IR_out[3:0]),
    .i_flags (status[4:1]),
    .o_taken (w_taken)
  );

  always_comb begin
    w_cw     = '0;
    w_const  = '0;
    w_next   = r_state;
    w_retire = 1'b0;
    unique case (r_state)
      FETCH: begin
        w_cw[CW_AS]        = 1'b1;
        w_cw[CW_DS +: 2]   = DS_MEM;
        w_cw[CW_IL]        = 1'b1;
        w_cw[CW_SIZE +: 2] = SZ_WORD;
        w_next             = EXECUTE;
      end
      EXECUTE: begin
        w_next   = FETCH;
        w_retire = 1'b1;
        unique case (1'b1)
          w_rtype: begin
            w_cw[CW_PS +: 2] = PS_INC;
            w_cw[CW_DS +: 2] = DS_ALU;
            w_cw[CW_RW]      = 1'b1;
            w_cw[CW_SL]      = w_rsl;
            w_cw[CW_FS +: 5] = w_rfs;
            w_cw[CW_C0]      = w_rc0;
            w_cw[CW_DA +: 5] = w_rd;
            w_cw[CW_SA +: 5] = w_rn;
            w_cw[CW_SB +: 5] = w_rm;
          end
          w_itype: begin
            w_cw[CW_PS +: 2] = PS_INC;
            w_cw[CW_DS +: 2] = DS_ALU;
            w_cw[CW_RW]      = 1'b1;
            w_cw[CW_BSEL]    = 1'b1;
            w_cw[CW_FS +: 5] = w_isub ? FS_SUB : FS_ADD;
            w_cw[CW_C0]      = w_isub;
            w_cw[CW_DA +: 5] = w_rd;
            w_cw[CW_SA +: 5] = w_rn;
            w_cw[CW_SB +: 5] = w_rm;
            w_const          = {52'd0, IR_out[21:10]};
          end
          w_ldur: begin
            w_cw[CW_PS +: 2]   = PS_INC;
            w_cw[CW_DS +: 2]   = DS_MEM;
            w_cw[CW_BSEL]      = 1'b1;
            w_cw[CW_FS +: 5]   = FS_ADD;
            w_cw[CW_SIZE +: 2] = SZ_DOUBLE;
            w_cw[CW_RW]        = 1'b1;
            w_cw[CW_DA +: 5]   = w_rd;
            w_cw[CW_SA +: 5]   = w_rn;
            w_const = {{55{IR_out[20]}}, IR_out[20:12]};
          end
          w_stur: begin
            w_cw[CW_PS +: 2]   = PS_INC;
            w_cw[CW_DS +: 2]   = DS_REG;
            w_cw[CW_BSEL]      = 1'b1;
            w_cw[CW_FS +: 5]   = FS_ADD;
            w_cw[CW_SIZE +: 2] = SZ_DOUBLE;
            w_cw[CW_MW]        = 1'b1;
            w_cw[CW_SA +: 5]   = w_rn;
            w_cw[CW_SB +: 5]   = w_rd;
            w_const = {{55{IR_out[20]}}, IR_out[20:12]};
          end
          w_b: begin
            w_cw[CW_PS +: 2] = PS_BR;
            w_cw[CW_PCSEL]   = 1'b0;
            w_const = {{36{IR_out[25]}}, IR_out[25:0], 2'b00};
          end
          w_cbz: begin
            w_cw[CW_PS +: 2] = status[0] ? PS_BR : PS_INC;
            w_cw[CW_FS +: 5] = FS_PASSA;
            w_cw[CW_SA +: 5] = w_rd;
            w_const = {{43{IR_out[23]}}, IR_out[23:5], 2'b00};
          end
          w_bc: begin
            w_cw[CW_PS +: 2] = w_taken ? PS_BR : PS_INC;
            w_const = {{43{IR_out[23]}}, IR_out[23:5], 2'b00};
          end
          default: begin
            w_next   = HALT;
            w_retire = 1'b0;
          end
        endcase
      end
      HALT: w_next = HALT;
      default: w_next = FETCH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= RESET_STATE;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire)
        r_count <= r_count + 16'd1;
    end
  end

  assign ControlWord = w_cw;
  assign constant    = w_const;
  assign state       = r_state;
  assign instr_count = r_count;

endmodule

// File: tb/tb_legv8_control_unit.sv
// Directed bench for legv8_control_unit: vector table per
// instruction plus HALT, undefined-opcode and mid-EXECUTE reset runs.
module tb_legv8_control_unit;

  logic        clock;
  logic        reset;
  logic [31:0] IR_out;
  logic [4:0]  status;
  logic [33:0] ControlWord;
  logic [63:0] constant;
  logic [1:0]  state;
  logic [15:0] instr_count;

  int total;
  int bad;
  logic [15:0] exp_cnt;

  typedef struct {
    logic [31:0] ir;
    logic [4:0]  st;
    logic [33:0] cw;
    logic [63:0] k;
  } vec_t;

  vec_t tbl[$];

  legv8_control_unit dut (
    .clock       (clock),
    .reset       (reset),
    .IR_out      (IR_out),
    .status      (status),
    .ControlWord (ControlWord),
    .constant    (constant),
    .state       (state),
    .instr_count (instr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [33:0] mkcw(
    logic as, logic [1:0] ds, logic [1:0] ps, logic pcsel,
    logic bsel, logic il, logic sl, logic [4:0] fs, logic c0,
    logic [1:0] sz, logic mw, logic rw,
    logic [4:0] da, logic [4:0] sa, logic [4:0] sb);
    return {as, ds, ps, pcsel, bsel, il, sl, fs, c0,
            sz, mw, rw, da, sa, sb};
  endfunction

  function automatic logic [33:0] cw_alu(
    logic [4:0] fs, logic c0, logic sl, logic bsel,
    logic [4:0] da, logic [4:0] sa, logic [4:0] sb);
    return mkcw(1'b0, 2'b00, 2'b01, 1'b0, bsel, 1'b0, sl, fs, c0,
                2'b00, 1'b0, 1'b1, da, sa, sb);
  endfunction

  function automatic logic [33:0] cw_br(
    logic [1:0] ps, logic [4:0] fs, logic [4:0] sa);
    return mkcw(1'b0, 2'b00, ps, 1'b0, 1'b0, 1'b0, 1'b0, fs, 1'b0,
                2'b00, 1'b0, 1'b0, 5'd0, sa, 5'd0);
  endfunction

  function automatic logic [31:0] er(
    logic [10:0] op, logic [4:0] rm, logic [4:0] rn, logic [4:0] rd);
    return {op, rm, 6'd0, rn, rd};
  endfunction

  function automatic logic [31:0] ei(
    logic [9:0] op, logic [11:0] imm, logic [4:0] rn, logic [4:0] rd);
    return {op, imm, rn, rd};
  endfunction

  function automatic logic [31:0] ed(
    logic [10:0] op, logic [8:0] imm, logic [4:0] rn, logic [4:0] rt);
    return {op, imm, 2'b00, rn, rt};
  endfunction

  function automatic logic [31:0] eb(logic [25:0] imm);
    return {6'b000101, imm};
  endfunction

  function automatic logic [31:0] ecb(logic [18:0] imm, logic [4:0] rt);
    return {8'b10110100, imm, rt};
  endfunction

  function automatic logic [31:0] ebc(logic [18:0] imm, logic [3:0] c);
    return {8'b01010100, imm, 1'b0, c};
  endfunction

  task automatic add(input logic [31:0] ir, input logic [4:0] st,
                     input logic [33:0] cw, input logic [63:0] k);
    vec_t v;
    v.ir = ir;
    v.st = st;
    v.cw = cw;
    v.k  = k;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  logic [33:0] fetch_cw;

  // Starts and ends at a negedge with the FSM in FETCH.
  task automatic run_vec(input int i);
    IR_out = tbl[i].ir;
    status = tbl[i].st;
    #1;
    chk($sformatf("v%0d_fetch_cw", i), 64'(ControlWord), 64'(fetch_cw));
    chk($sformatf("v%0d_fetch_k", i), constant, 64'd0);
    @(posedge clock);
    @(negedge clock);
    chk($sformatf("v%0d_state", i), 64'(state), 64'd1);
    chk($sformatf("v%0d_cw", i), 64'(ControlWord), 64'(tbl[i].cw));
    chk($sformatf("v%0d_k", i), constant, tbl[i].k);
    chk($sformatf("v%0d_rwmw", i),
        64'(ControlWord[16] & ControlWord[15]), 64'd0);
    @(posedge clock);
    @(negedge clock);
    exp_cnt = exp_cnt + 16'd1;
    chk($sformatf("v%0d_back", i), 64'(state), 64'd0);
    chk($sformatf("v%0d_cnt", i), 64'(instr_count), 64'(exp_cnt));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    exp_cnt = 16'd0;
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_cnt", 64'(instr_count), 64'd0);
    chk("rst_cw", 64'(ControlWord), 64'(fetch_cw));
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic run_halt(input logic [31:0] ir, input string nm);
    logic [15:0] held;
    held = exp_cnt;
    IR_out = ir;
    @(posedge clock);
    @(negedge clock);
    chk({nm, "_ex_cw"}, 64'(ControlWord), 64'd0);
    chk({nm, "_ex_k"}, constant, 64'd0);
    @(posedge clock);
    @(negedge clock);
    chk({nm, "_state"}, 64'(state), 64'd3);
    for (int c = 0; c < 10; c++) begin
      IR_out = 32'h8B020023;
      @(posedge clock);
      @(negedge clock);
      chk($sformatf("%s_h%0d_cw", nm, c), 64'(ControlWord), 64'd0);
      chk($sformatf("%s_h%0d_k", nm, c), constant, 64'd0);
      chk($sformatf("%s_h%0d_st", nm, c), 64'(state), 64'd3);
    end
    chk({nm, "_cnt"}, 64'(instr_count), 64'(held));
    do_reset();
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    exp_cnt = 16'd0;
    reset   = 1'b1;
    IR_out  = 32'd0;
    status  = 5'd0;
    fetch_cw = mkcw(1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0,
                    5'd0, 1'b0, 2'b10, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);

    add(32'h8B020023, 5'd0, cw_alu(5'b01000, 0, 0, 0, 3, 1, 2), 0);
    add(er(11'b11001011000, 7, 6, 5), 5'd0,
        cw_alu(5'b01001, 1, 0, 0, 5, 6, 7), 0);
    add(er(11'b10001010000, 3, 2, 1), 5'd0,
        cw_alu(5'b00000, 0, 0, 0, 1, 2, 3), 0);
    add(er(11'b10101010000, 6, 5, 4), 5'd0,
        cw_alu(5'b00100, 0, 0, 0, 4, 5, 6), 0);
    add(er(11'b10101011000, 9, 8, 7), 5'd0,
        cw_alu(5'b01000, 0, 1, 0, 7, 8, 9), 0);
    add(er(11'b11101011000, 12, 11, 10), 5'd0,
        cw_alu(5'b01001, 1, 1, 0, 10, 11, 12), 0);
    add(ei(10'b1001000100, 12'hFFF, 3, 2), 5'd0,
        cw_alu(5'b01000, 0, 0, 1, 2, 3, 31), 64'hFFF);
    add(ei(10'b1101000100, 12'd1, 10, 9), 5'd0,
        cw_alu(5'b01001, 1, 0, 1, 9, 10, 0), 64'd1);
    add(ed(11'b11111000010, 9'h1F8, 2, 5), 5'd0,
        mkcw(0, 2'b11, 2'b01, 0, 1, 0, 0, 5'b01000, 0, 2'b11,
             0, 1, 5, 2, 0), 64'hFFFF_FFFF_FFFF_FFF8);
    add(ed(11'b11111000000, 9'd16, 1, 6), 5'd0,
        mkcw(0, 2'b01, 2'b01, 0, 1, 0, 0, 5'b01000, 0, 2'b11,
             1, 0, 0, 1, 6), 64'd16);
    add(eb(26'h3FF_FFFF), 5'd0, cw_br(2'b10, 0, 0),
        64'hFFFF_FFFF_FFFF_FFFC);
    add(eb(26'd8), 5'd0, cw_br(2'b10, 0, 0), 64'd32);
    add(ecb(19'd16, 4), 5'b00001, cw_br(2'b10, 5'b01100, 4), 64'd64);
    add(ecb(19'd16, 4), 5'b11110, cw_br(2'b01, 5'b01100, 4), 64'd64);
    add(ecb(19'h7FFFF, 9), 5'b00001, cw_br(2'b10, 5'b01100, 9),
        64'hFFFF_FFFF_FFFF_FFFC);
    add(ebc(19'd2, 4'b0000), 5'b00010, cw_br(2'b10, 0, 0), 64'd8);
    add(ebc(19'd2, 4'b0000), 5'b00001, cw_br(2'b01, 0, 0), 64'd8);
    add(ebc(19'd2, 4'b0001), 5'b00000, cw_br(2'b10, 0, 0), 64'd8);
    add(ebc(19'd2, 4'b1100), 5'b10100, cw_br(2'b10, 0, 0), 64'd8);
    add(ebc(19'd2, 4'b1100), 5'b10110, cw_br(2'b01, 0, 0), 64'd8);
    add(ebc(19'd2, 4'b1011), 5'b00100, cw_br(2'b10, 0, 0), 64'd8);
    add(ebc(19'd2, 4'b1011), 5'b10100, cw_br(2'b01, 0, 0), 64'd8);
    add(ebc(19'd2, 4'b1000), 5'b01000, cw_br(2'b10, 0, 0), 64'd8);
    add(ebc(19'd2, 4'b1000), 5'b01010, cw_br(2'b01, 0, 0), 64'd8);
    add(ebc(19'd2, 4'b1101), 5'b00010, cw_br(2'b10, 0, 0), 64'd8);
    add(ebc(19'd2, 4'b1110), 5'b00000, cw_br(2'b10, 0, 0), 64'd8);
    add(ebc(19'd2, 4'b1111), 5'b00000, cw_br(2'b10, 0, 0), 64'd8);
    add(ebc(19'd2, 4'b0110), 5'b10000, cw_br(2'b10, 0, 0), 64'd8);
    add(ebc(19'd2, 4'b0011), 5'b01000, cw_br(2'b01, 0, 0), 64'd8);

    @(negedge clock);
    do_reset();

    for (int i = 0; i < tbl.size(); i++)
      run_vec(i);

    run_halt(32'h0000_0000, "halt0");
    run_halt(32'hFFFF_FFFF, "undef");

    run_vec(0);
    run_vec(1);
    IR_out = ed(11'b11111000000, 9'd16, 1, 6);
    @(posedge clock);
    @(negedge clock);
    chk("stur_mw", 64'(ControlWord[16]), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    exp_cnt = 16'd0;
    chk("mid_mw", 64'(ControlWord[16]), 64'd0);
    chk("mid_cw", 64'(ControlWord), 64'(fetch_cw));
    chk("mid_state", 64'(state), 64'd0);
    chk("mid_cnt", 64'(instr_count), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    IR_out = 32'h8B020023;
    @(posedge clock);
    @(negedge clock);
    chk("post_rst_fetch", 64'(state), 64'd1);
    @(posedge clock);
    @(negedge clock);
    chk("post_rst_cnt", 64'(instr_count), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
